voice_mixer: RTL and testbench

//  Frame-rate mixer feeding the sigma-delta DAC wrapper. On each smpl_rate_trig it

---
 rtl/voice_mixer_pkg.sv | 18 +
 rtl/voice_mixer_if.sv | 12 +
 rtl/voice_mixer_saturate.sv | 22 ++
 rtl/voice_mixer.sv | 143 ++++++++++++++
 tb/tb_voice_mixer.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/voice_mixer_pkg.sv
// Shared sample format constants and mixer FSM encoding.
// Q2.16 samples: +1.0 is 0x10000, -1.0 is 0x30000 in 18-bit two's complement.
package voice_mixer_pkg;
  localparam int SMPL_W    = 18;
  localparam int SMPL_FRAC = 16;
  localparam int IDX_W     = 4;

  localparam logic [SMPL_W-1:0] SMPL_POS_ONE = 18'h10000;
  localparam logic [SMPL_W-1:0] SMPL_NEG_ONE = 18'h30000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SCALE = 3'd3,
    ST_OUT   = 3'd4
  } state_t;
endpackage

// File: rtl/voice_mixer_if.sv
// Mixer <-> voice generator polling bus: one-cycle req with index, one-cycle rdy with sample.
interface voice_mixer_if;
  import voice_mixer_pkg::*;

  logic              voice_req;
  logic [IDX_W-1:0]  voice_idx;
  logic              voice_rdy;
  logic [SMPL_W-1:0] voice_smpl;

  modport master (output voice_req, output voice_idx, input voice_rdy, input voice_smpl);
  modport slave  (input voice_req, input voice_idx, output voice_rdy, output voice_smpl);
endinterface

// File: rtl/voice_mixer_saturate.sv
// smpl_saturate: clamps a wide signed Q.16 value to the Q2.16 range [-1.0, +1.0].
// Combinational; exactly +/-1.0 pass through unchanged.
module smpl_saturate
  import voice_mixer_pkg::*;
#(
  parameter int IN_W = 20
) (
  input  logic signed [IN_W-1:0]   i_din,
  output logic        [SMPL_W-1:0] o_dout
);
  localparam logic signed [IN_W-1:0] C_POS = IN_W'(1 << SMPL_FRAC);
  localparam logic signed [IN_W-1:0] C_NEG = -C_POS;

  always_comb begin
    o_dout = i_din[SMPL_W-1:0];
    if (i_din > C_POS) begin
      o_dout = SMPL_POS_ONE;
    end else if (i_din < C_NEG) begin
      o_dout = SMPL_NEG_ONE;
    end
  end
endmodule

// File: rtl/voice_mixer.sv
// Per-frame mixer: polls NVOICES voices, sums, applies master volume, saturates to +/-1.0.
// smpl_rdy 2*NVOICES+3 cycles after trig (+1 per late WAIT cycle); trig while busy sets overrun.
module voice_mixer
  import voice_mixer_pkg::*;
#(
  parameter int NVOICES     = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_smpl_rate_trig,
  input  logic [15:0]       i_master_vol,
  voice_mixer_if.master     vif,
  output logic              o_smpl_rdy,
  output logic [SMPL_W-1:0] o_smpl,
  output logic              o_busy,
  output logic              o_voice_timeout,
  output logic              o_overrun
);
  localparam int ACC_W  = SMPL_W + $clog2(NVOICES);
  localparam int PROD_W = ACC_W + 17;
  localparam int TMO_W  = $clog2(TIMEOUT_CYC);

  state_t                    r_state, w_next;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [ACC_W:0]     r_scaled;
  logic [IDX_W-1:0]          r_idx;
  logic [TMO_W-1:0]          r_tmo_cnt;
  logic                      r_voice_req, r_smpl_rdy, r_busy, r_voice_timeout, r_overrun;
  logic [SMPL_W-1:0]         r_smpl;

  logic                      w_accept, w_tmo_hit, w_voice_done, w_last;
  logic                      w_voice_req_nxt, w_smpl_rdy_nxt, w_busy_nxt;
  logic                      w_timeout_nxt, w_overrun_nxt;
  logic signed [ACC_W-1:0]   w_smpl_x;
  logic signed [PROD_W-1:0]  w_acc_x, w_vol_x, w_prod;
  logic signed [ACC_W:0]     w_scaled;
  logic [SMPL_W-1:0]         w_sat;
  logic                      w_unused;

  // busy covers the smpl_rdy cycle too, so it alone gates trig acceptance
  assign w_accept     = i_smpl_rate_trig && !r_busy;
  assign w_tmo_hit    = !vif.voice_rdy && (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
  assign w_voice_done = (r_state == ST_WAIT) && (vif.voice_rdy || w_tmo_hit);
  assign w_last       = (r_idx == IDX_W'(NVOICES - 1));

  assign w_smpl_x = ACC_W'($signed(vif.voice_smpl));
  assign w_acc_x  = PROD_W'(r_acc);
  assign w_vol_x  = PROD_W'($signed({1'b0, i_master_vol}));
  assign w_prod   = w_acc_x * w_vol_x;
  assign w_scaled = w_prod[PROD_W-1:SMPL_FRAC];
  assign w_unused = ^w_prod[SMPL_FRAC-1:0];

  smpl_saturate #(.IN_W(ACC_W + 1)) u_sat (
    .i_din  (r_scaled),
    .o_dout (w_sat)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = ST_REQ;
      ST_REQ:   w_next = ST_WAIT;
      ST_WAIT:  if (w_voice_done) w_next = w_last ? ST_SCALE : ST_REQ;
      ST_SCALE: w_next = ST_OUT;
      ST_OUT:   w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_voice_req_nxt = (w_next == ST_REQ);
    w_smpl_rdy_nxt  = (r_state == ST_OUT);
    w_busy_nxt      = r_busy;
    if (w_accept) begin
      w_busy_nxt = 1'b1;
    end else if (r_state == ST_IDLE) begin
      w_busy_nxt = 1'b0;
    end
    w_overrun_nxt = r_overrun || (i_smpl_rate_trig && r_busy);
    w_timeout_nxt = r_voice_timeout || ((r_state == ST_WAIT) && w_tmo_hit);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_acc           <= '0;
      r_scaled        <= '0;
      r_idx           <= '0;
      r_tmo_cnt       <= '0;
      r_voice_req     <= 1'b0;
      r_smpl_rdy      <= 1'b0;
      r_busy          <= 1'b0;
      r_voice_timeout <= 1'b0;
      r_overrun       <= 1'b0;
      r_smpl          <= '0;
    end else begin
      r_voice_req     <= w_voice_req_nxt;
      r_smpl_rdy      <= w_smpl_rdy_nxt;
      r_busy          <= w_busy_nxt;
      r_voice_timeout <= w_timeout_nxt;
      r_overrun       <= w_overrun_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_acc <= '0;
            r_idx <= '0;
          end
        end
        ST_REQ: r_tmo_cnt <= '0;
        ST_WAIT: begin
          // a timed-out voice contributes nothing to the sum
          if (vif.voice_rdy) begin
            r_acc <= r_acc + w_smpl_x;
          end else if (!w_tmo_hit) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          end
          if (w_voice_done && !w_last) begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        ST_SCALE: r_scaled <= w_scaled;
        ST_OUT:   r_smpl   <= w_sat;
        default: ;
      endcase
    end
  end

  assign vif.voice_req   = r_voice_req;
  assign vif.voice_idx   = r_idx;
  assign o_smpl_rdy      = r_smpl_rdy;
  assign o_smpl          = r_smpl;
  assign o_busy          = r_busy;
  assign o_voice_timeout = r_voice_timeout;
  assign o_overrun       = r_overrun;
endmodule

// File: tb/tb_voice_mixer.sv
// Bench for voice_mixer: voice responder with per-voice sample/delay, arithmetic mix model,
// per-strobe compare of smpl and latency, plus literal expectations for each directed case.
module tb_voice_mixer;
  localparam int N   = 4;
  localparam int TMO = 64;

  logic        clk  = 1'b0;
  logic        rst  = 1'b0;
  logic        trig = 1'b0;
  logic [15:0] vol  = '0;
  logic        smpl_rdy, busy, vto, ovr;
  logic [17:0] smpl;

  voice_mixer_if vif ();

  voice_mixer #(.NVOICES(N), .TIMEOUT_CYC(TMO)) dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_smpl_rate_trig (trig),
    .i_master_vol     (vol),
    .vif              (vif),
    .o_smpl_rdy       (smpl_rdy),
    .o_smpl           (smpl),
    .o_busy           (busy),
    .o_voice_timeout  (vto),
    .o_overrun        (ovr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_rdy = 0;
  logic [17:0] last_smpl = '0;
  int          last_lat = 0;
  logic [17:0] v_val [N];
  int          v_dly [N];   // cycles from req to rdy; 0 = never answers
  logic [3:0]  req_log [$];

  typedef struct {
    logic [17:0] smpl;
    int          trig_cyc;
    int          lat;
  } exp_t;
  exp_t exp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  function automatic logic [17:0] model_mix(input logic [15:0] g);
    longint sum = 0;
    longint scaled;
    for (int i = 0; i < N; i++)
      if (v_dly[i] >= 1 && v_dly[i] <= TMO) sum += longint'($signed(v_val[i]));
    scaled = (sum * longint'(g)) >>> 16;
    if (scaled > 65536)  return 18'h10000;
    if (scaled < -65536) return 18'h30000;
    return 18'(scaled);
  endfunction

  function automatic int model_lat();
    int lat = 2 * N + 3;
    for (int i = 0; i < N; i++)
      lat += (v_dly[i] >= 1 && v_dly[i] <= TMO) ? v_dly[i] - 1 : TMO - 1;
    return lat;
  endfunction

  // voice generators
  initial begin
    int cd;
    cd = 0;
    vif.voice_rdy  = 1'b0;
    vif.voice_smpl = '0;
    forever begin
      @(negedge clk);
      vif.voice_rdy = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) vif.voice_rdy = 1'b1;
      end
      if (vif.voice_req) begin
        req_log.push_back(vif.voice_idx);
        vif.voice_smpl = v_val[int'(vif.voice_idx)];
        cd = v_dly[int'(vif.voice_idx)];
      end
    end
  end

  // compare process
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && smpl_rdy) begin
        n_rdy++;
        if (exp_q.size() == 0) begin
          chk("unexpected_smpl_rdy", smpl_rdy, 0);
        end else begin
          e = exp_q.pop_front();
          chk("mix_smpl", smpl, e.smpl);
          chk("mix_latency", cyc - e.trig_cyc, e.lat);
          last_smpl = smpl;
          last_lat  = cyc - e.trig_cyc;
        end
      end
    end
  end

  task automatic set_voices(input logic [17:0] a, b, c, d, input int da, db, dc, dd);
    v_val[0] = a;  v_val[1] = b;  v_val[2] = c;  v_val[3] = d;
    v_dly[0] = da; v_dly[1] = db; v_dly[2] = dc; v_dly[3] = dd;
  endtask

  task automatic start_frame(input logic [15:0] g);
    @(negedge clk);
    vol  = g;
    trig = 1'b1;
    exp_q.push_back('{model_mix(g), cyc, model_lat()});
    @(negedge clk);
    trig = 1'b0;
    chk("busy_after_trig", busy, 1);
    chk("req_after_trig", vif.voice_req, 1);
    chk("idx_after_trig", vif.voice_idx, 0);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("frame_done_in_bound", (exp_q.size() == 0 && !busy), 1);
    @(negedge clk);
  endtask

  task automatic run_frame(input logic [15:0] g);
    start_frame(g);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    set_voices('0, '0, '0, '0, 1, 1, 1, 1);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rst_smpl_rdy", smpl_rdy, 0);
    chk("rst_smpl", smpl, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", vto, 0);
    chk("rst_overrun", ovr, 0);
    chk("rst_voice_req", vif.voice_req, 0);
    chk("rst_voice_idx", vif.voice_idx, 0);
    @(negedge clk);
    rst = 1'b0;

    // basic mix, prompt voices
    set_voices(18'h01000, 18'h02000, 18'h03000, 18'h04000, 1, 1, 1, 1);
    req_log.delete();
    run_frame(16'hFFFF);
    chk("t1_smpl", last_smpl, 18'h09FFF);
    chk("t1_latency", last_lat, 11);
    chk("t1_req_count", req_log.size(), 4);
    for (int i = 0; i < N; i++) chk("t1_req_idx", req_log[i], i);

    // +1.0 input at full volume, with late voices
    set_voices(18'h04000, 18'h04000, 18'h04000, 18'h04000, 1, 2, 3, 1);
    run_frame(16'hFFFF);
    chk("unity_minus_lsb", last_smpl, 18'h0FFFF);
    chk("late_latency", last_lat, 14);

    // saturation
    set_voices(18'h0C000, 18'h0C000, 18'h0C000, 18'h0C000, 1, 1, 1, 1);
    run_frame(16'hFFFF);
    chk("sat_pos", last_smpl, 18'h10000);
    set_voices(18'h34000, 18'h34000, 18'h34000, 18'h34000, 1, 1, 1, 1);
    run_frame(16'hFFFF);
    chk("sat_neg", last_smpl, 18'h30000);
    chk("sat_no_timeout", vto, 0);
    chk("sat_no_overrun", ovr, 0);

    // voice 2 never answers
    set_voices(18'h01000, 18'h01000, 18'h01000, 18'h01000, 1, 1, 0, 1);
    run_frame(16'hFFFF);
    chk("tmo_smpl", last_smpl, 18'h02FFF);
    chk("tmo_latency", last_lat, 74);
    chk("tmo_sticky", vto, 1);

    // overrun: second trig 3 cycles after the first
    set_voices(18'h01000, 18'h02000, 18'h03000, 18'h04000, 1, 1, 1, 1);
    n0 = n_rdy;
    start_frame(16'hFFFF);
    @(negedge clk);
    @(negedge clk);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    chk("ovr_flag", ovr, 1);
    wait_idle();
    chk("ovr_one_strobe", n_rdy - n0, 1);
    chk("ovr_smpl", last_smpl, 18'h09FFF);
    set_voices(18'h04000, 18'h04000, 18'h04000, 18'h04000, 1, 1, 1, 1);
    run_frame(16'hFFFF);
    chk("post_ovr_smpl", last_smpl, 18'h0FFFF);

    // reset during WAIT of voice 1
    set_voices(18'h01000, 18'h02000, 18'h03000, 18'h04000, 1, 0, 1, 1);
    start_frame(16'hFFFF);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_smpl", smpl, 0);
    chk("midrst_smpl_rdy", smpl_rdy, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_voice_req", vif.voice_req, 0);
    chk("midrst_timeout", vto, 0);
    chk("midrst_overrun", ovr, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_idle_busy", busy, 0);
    set_voices(18'h01000, 18'h02000, 18'h03000, 18'h04000, 1, 1, 1, 1);
    req_log.delete();
    run_frame(16'hFFFF);
    chk("midrst_first_idx", req_log[0], 0);
    chk("midrst_req_count", req_log.size(), 4);
    chk("midrst_smpl_after", last_smpl, 18'h09FFF);

    // volume scaling
    set_voices(18'h02000, 18'h02000, 18'h02000, 18'h02000, 1, 1, 1, 1);
    run_frame(16'h8000);
    chk("half_vol", last_smpl, 18'h04000);
    run_frame(16'h0000);
    chk("zero_vol", last_smpl, 18'h00000);
    set_voices(18'h3F000, 18'h3F000, 18'h3F000, 18'h3F000, 1, 1, 1, 1);
    run_frame(16'hFFFF);
    chk("neg_mix", last_smpl, 18'h3C000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
